// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with a level interrupt output.
// Defining TIMER_PRESCALE_EN adds the PRESC register and the prescale counter.
module timer_counter #(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Dev_Addr,
   input  logic [31:0] Dev_DataIn,
   input  logic        WE,
   output logic [31:0] RD,
   output logic        IRQ
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [3:0]         ctrl_q, ctrl_d;
   logic [31:0]        preset_q, preset_d;
   logic [31:0]        count_q, count_d;
   logic               irq_q, irq_d;
   logic [PRESC_W-1:0] presc_rd;
   logic               tick;

`ifdef TIMER_PRESCALE_EN
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] psc_cnt_q, psc_cnt_d;

   assign tick     = (psc_cnt_q == presc_q);
   assign presc_rd = presc_q;
`else
   assign tick     = 1'b1;
   assign presc_rd = '0;
`endif

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      irq_d    = irq_q;
`ifdef TIMER_PRESCALE_EN
      presc_d   = presc_q;
      psc_cnt_d = psc_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (ctrl_q[0]) state_d = S_LOAD;
         end
         S_LOAD: begin
            count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
            psc_cnt_d = '0;
`endif
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_q[0]) begin
               state_d = S_IDLE;
            end else if (count_q == 32'd0) begin
               state_d = S_INT;
               irq_d   = 1'b1;
            end else begin
`ifdef TIMER_PRESCALE_EN
               psc_cnt_d = tick ? '0 : psc_cnt_q + PRESC_W'(1);
`endif
               if (tick) count_d = count_q - 32'd1;
            end
         end
         default: begin
            if (ctrl_q[2:1] == 2'b01) begin
               state_d = S_LOAD;
               irq_d   = 1'b0;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = S_IDLE;
            end
         end
      endcase

      // Bus writes win over the FSM's own EN/irq updates.
      if (WE) begin
         case (Dev_Addr)
            2'd0: begin
               ctrl_d = Dev_DataIn[3:0];
               irq_d  = 1'b0;
               if (!Dev_DataIn[0]) state_d = S_IDLE;
            end
            2'd1: preset_d = Dev_DataIn;
`ifdef TIMER_PRESCALE_EN
            2'd3: presc_d = Dev_DataIn[PRESC_W-1:0];
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
         presc_q   <= '0;
         psc_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         irq_q    <= irq_d;
`ifdef TIMER_PRESCALE_EN
         presc_q   <= presc_d;
         psc_cnt_q <= psc_cnt_d;
`endif
      end
   end

   always_comb begin
      case (Dev_Addr)
         2'd0:    RD = {28'd0, ctrl_q};
         2'd1:    RD = preset_q;
         2'd2:    RD = count_q;
         default: RD = 32'(presc_rd);
      endcase
   end

   assign IRQ = irq_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Randomised and directed bench for timer_counter against a timeline model.
// Works for both builds (with or without TIMER_PRESCALE_EN).
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  Dev_Addr;
   logic [31:0] Dev_DataIn;
   logic        WE;
   logic [31:0] RD;
   logic        IRQ;

   int errs   = 0;
   int checks = 0;

   timer_counter dut (
      .clk        (clk),
      .reset      (reset),
      .Dev_Addr   (Dev_Addr),
      .Dev_DataIn (Dev_DataIn),
      .WE         (WE),
      .RD         (RD),
      .IRQ        (IRQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Timeline model: a run is described by the edge t0 at which COUNT
   // is loaded with L; everything else follows arithmetically from it.
   bit          m_en, m_im, m_flag, m_busy;
   bit [1:0]    m_mode;
   logic [31:0] m_pre, m_cnt;
   longint      m_k, m_t0, m_L, m_N;
   longint      m_presc;

   function automatic void mdl_reset();
      m_en = 0; m_im = 0; m_flag = 0; m_busy = 0; m_mode = 0;
      m_pre = 0; m_cnt = 0; m_k = 0; m_t0 = 0; m_L = 0; m_N = 1;
      m_presc = 0;
   endfunction

   function automatic void mdl_edge();
      longint d;
      m_k++;
      if (m_busy) begin
         d = m_k - m_t0;
         if (d == 0) begin
            m_L   = longint'(m_pre);
            m_N   = m_presc + 1;
            m_cnt = m_pre;
         end else if (d > 0 && d <= m_L * m_N) begin
            m_cnt = 32'(m_L - d / m_N);
         end else if (d == m_L * m_N + 1) begin
            m_flag = 1;
         end else if (d == m_L * m_N + 2) begin
            if (m_mode == 2'b01) begin
               m_flag = 0;
               m_t0   = m_k + 1;
            end else begin
               m_en   = 0;
               m_busy = 0;
            end
         end
      end else if (m_en) begin
         m_busy = 1;
         m_t0   = m_k + 1;
      end
   endfunction

   function automatic void mdl_write(input logic [1:0] a, input logic [31:0] d);
      case (a)
         2'd0: begin
            m_en   = d[0];
            m_mode = d[2:1];
            m_im   = d[3];
            m_flag = 0;
            if (!d[0]) m_busy = 0;
         end
         2'd1: m_pre = d;
`ifdef TIMER_PRESCALE_EN
         2'd3: m_presc = longint'(d[15:0]);
`endif
         default: ;
      endcase
   endfunction

   task automatic check_all();
      Dev_Addr = 2'd0; #1;
      check("ctrl", RD, {28'd0, m_im, m_mode, m_en});
      Dev_Addr = 2'd1; #1;
      check("preset", RD, m_pre);
      Dev_Addr = 2'd2; #1;
      check("count", RD, m_cnt);
      Dev_Addr = 2'd3; #1;
      check("presc", RD, 32'(m_presc));
      check("irq", 32'(IRQ), 32'(m_flag & m_im));
   endtask

   task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] d);
      WE = we; Dev_Addr = a; Dev_DataIn = d;
      @(posedge clk); #1;
      WE = 1'b0;
      mdl_edge();
      if (we) mdl_write(a, d);
      check_all();
   endtask

   task automatic rd(input logic [1:0] a);
      Dev_Addr = a; #1;
   endtask

   initial begin
      reset = 1'b1; WE = 1'b0; Dev_Addr = 2'd0; Dev_DataIn = '0;
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;

      // reset in the middle of a count
      cyc(1, 2'd1, 32'd10);
      cyc(1, 2'd0, 32'h1);
      for (int i = 1; i <= 6; i++) cyc(0, 2'd0, 32'd0);
      #2 reset = 1'b1;
      mdl_reset();
      rd(2'd0); check("rst_ctrl", RD, 32'd0);
      rd(2'd1); check("rst_preset", RD, 32'd0);
      rd(2'd2); check("rst_count", RD, 32'd0);
      check("rst_irq", 32'(IRQ), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check_all();

      // one-shot with interrupt held until CTRL write
      cyc(1, 2'd1, 32'd5);
      cyc(1, 2'd0, 32'h9);
      for (int i = 1; i <= 12; i++) begin
         cyc(0, 2'd0, 32'd0);
         if (i == 7) check("os_irq_e7", 32'(IRQ), 32'd0);
         if (i == 8) check("os_irq_e8", 32'(IRQ), 32'd1);
      end
      rd(2'd0); check("os_ctrl", RD, 32'h8);
      check("os_irq_hold", 32'(IRQ), 32'd1);
      cyc(1, 2'd0, 32'h0);
      check("os_irq_clr", 32'(IRQ), 32'd0);

      // auto-reload pulses
      cyc(1, 2'd1, 32'd3);
      cyc(1, 2'd0, 32'hB);
      for (int i = 1; i <= 14; i++) begin
         cyc(0, 2'd0, 32'd0);
         if (i >= 2 && i <= 5) begin
            rd(2'd2); check("ar_cnt", RD, 32'(5 - i));
         end
         check("ar_irq", 32'(IRQ), (i == 6 || i == 12) ? 32'd1 : 32'd0);
      end
      cyc(1, 2'd0, 32'h0);

      // PRESET write mid-run, COUNT write ignored
      cyc(1, 2'd1, 32'd6);
      cyc(1, 2'd0, 32'h3);
      for (int i = 1; i <= 12; i++) begin
         if (i == 5)      cyc(1, 2'd1, 32'd100);
         else if (i == 6) cyc(1, 2'd2, 32'd7);
         else             cyc(0, 2'd0, 32'd0);
         rd(2'd2);
         if (i == 8)  check("pw_cnt_old", RD, 32'd0);
         if (i == 11) check("pw_cnt_new", RD, 32'd100);
         if (i == 12) check("pw_cnt_dec", RD, 32'd99);
      end
      cyc(1, 2'd0, 32'h0);

      // masked interrupt, EN self-clears; then PRESET=0
      cyc(1, 2'd1, 32'd2);
      cyc(1, 2'd0, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 2'd0, 32'd0);
         check("im0_irq", 32'(IRQ), 32'd0);
         rd(2'd2);
         if (i == 4) check("im0_cnt", RD, 32'd0);
         rd(2'd0);
         if (i == 8) check("im0_ctrl", RD, 32'd0);
      end
      cyc(1, 2'd1, 32'd0);
      cyc(1, 2'd0, 32'h9);
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 2'd0, 32'd0);
         if (i == 2) check("p0_irq_e2", 32'(IRQ), 32'd0);
         if (i == 3) check("p0_irq_e3", 32'(IRQ), 32'd1);
      end
      cyc(1, 2'd0, 32'h0);

`ifdef TIMER_PRESCALE_EN
      cyc(1, 2'd3, 32'd3);
      cyc(1, 2'd1, 32'd4);
      cyc(1, 2'd0, 32'h9);
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 2'd0, 32'd0);
         if (i == 18) check("psc_irq_e18", 32'(IRQ), 32'd0);
         if (i == 19) check("psc_irq_e19", 32'(IRQ), 32'd1);
      end
      rd(2'd3); check("psc_rd", RD, 32'd3);
      cyc(1, 2'd0, 32'h0);
`else
      cyc(1, 2'd3, 32'd3);
      rd(2'd3); check("psc_absent", RD, 32'd0);
`endif

      // randomised episodes
      for (int ep = 0; ep < 40; ep++) begin
         logic [31:0] pre;
         logic [1:0]  mode;
         logic        im;
         int          n;
         cyc(1, 2'd0, 32'h0);
`ifdef TIMER_PRESCALE_EN
         cyc(1, 2'd3, 32'($urandom_range(0, 2)));
`endif
         pre  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
         mode = 2'($urandom_range(0, 3));
         im   = 1'($urandom_range(0, 1));
         cyc(1, 2'd1, pre);
         cyc(1, 2'd0, {28'd0, im, mode, 1'b1});
         n = int'($urandom_range(15, 35));
         for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 15))
               0:       cyc(1, 2'd1, 32'($urandom_range(0, 6)));
               1:       cyc(1, 2'd2, $urandom);
               2:       cyc(1, 2'd0, $urandom);
               default: cyc(0, 2'd0, 32'd0);
            endcase
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
